// File: rtl/wave_display_pkg.sv
// Shared definitions for the waveform display path.
// The capture block, this reader and the VGA top all use these, so the RAM
// geometry and pixel layout have a single source.
//   SAMPLES   - samples per bank (one bank is one displayed line of the wave)
//   RAM_AW    - waveform RAM address width: {bank, sample index}
//   SAMPLE_W  - width of one offset-binary sample
//   pixel_rgb_t - packed {r,g,b} colour, 8 bits per channel
package wave_display_pkg;

    localparam int SAMPLES  = 256;
    localparam int RAM_AW   = 9;
    localparam int SAMPLE_W = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_rgb_t;

endpackage

// File: rtl/dff_arn.sv
// D flip-flop bank with an asynchronous active-low reset to a fixed value.
// Every state register of the display reader is built from this so that a
// reset anywhere in the frame clears the whole pipeline at once.
// Ports:
//   clk      - clock
//   reset_n  - asynchronous, active-low reset
//   d        - next value, captured on the rising clock edge
//   q        - registered value, RESET_VAL while reset_n is low
module dff_arn #(
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Plain register; the reset value is a parameter so idle can reset high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/wave_display_reader.sv
// Read side of the double-buffered waveform RAM.
// Turns raster coordinates into RAM read addresses from the bank frozen at
// the start of the window, then draws a vertical segment between each pair
// of adjacent samples. Each sample spans two pixel columns. Colour appears
// three clocks after the coordinate that produced it.
// Ports:
//   clk, reset_n        - clock and asynchronous active-low reset
//   x, y, valid         - raster column/row and visible-area qualifier
//   read_index          - bank the capture side exposes for reading
//   read_address        - {bank, sample index} to the RAM, combinational from x
//   read_value          - RAM data, one clock after read_address
//   valid_pixel         - pixel lies inside the wave window
//   r, g, b             - pixel colour
//   wave_display_idle   - raster outside window rows, bank swap is safe
module wave_display_reader
    import wave_display_pkg::*;
#(
    parameter logic [10:0] X_OFFSET   = 11'd128,
    parameter logic [9:0]  Y_TOP      = 10'd32,
    parameter logic [23:0] WAVE_COLOR = 24'hFFFFFF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [10:0]         x,
    input  logic [9:0]          y,
    input  logic                valid,
    input  logic                read_index,
    output logic [RAM_AW-1:0]   read_address,
    input  logic [SAMPLE_W-1:0] read_value,
    output logic                valid_pixel,
    output logic [7:0]          r,
    output logic [7:0]          g,
    output logic [7:0]          b,
    output logic                wave_display_idle
);

    localparam int IDX_W = $clog2(SAMPLES);

    logic [10:0]         rel_x;
    logic [9:0]          rel_y;
    logic                rows_in;
    logic                in_win;
    logic                newcol;
    logic                first;

    logic                idle_q;
    logic                bank_q;

    logic [10:0]         s1_q;
    logic                s1_in_win;
    logic                s1_newcol;
    logic                s1_first;
    logic [7:0]          s1_rel_y;

    logic [SAMPLE_W-1:0] cur_q;
    logic [SAMPLE_W-1:0] prev_q;
    logic [SAMPLE_W-1:0] cur_d;
    logic [SAMPLE_W-1:0] prev_d;
    logic                seen_q;

    logic [8:0]          s2_q;
    logic                s2_in_win;
    logic [7:0]          s2_rel_y;

    logic [7:0]          row;
    logic [SAMPLE_W-1:0] lo;
    logic [SAMPLE_W-1:0] hi;
    logic                hit;
    logic [23:0]         rgb_d;
    logic [23:0]         rgb_q;
    pixel_rgb_t          pix;

    // Window decode. Coordinates left of / above the window wrap to large
    // values, so a single upper-bound test per axis covers both sides.
    assign rel_x   = x - X_OFFSET;
    assign rel_y   = y - Y_TOP;
    assign rows_in = (rel_y[9:8] == 2'b00);
    assign in_win  = valid & (rel_x[10:9] == 2'b00) & rows_in;
    assign newcol  = in_win & ~rel_x[0];
    assign first   = newcol & (rel_x[IDX_W:1] == '0);

    // Idle follows the row every cycle, independent of valid, so blanking
    // lines below the window open the swap opportunity.
    dff_arn #(.W(1), .RESET_VAL(1'b1)) u_idle (
        .clk(clk), .reset_n(reset_n), .d(~rows_in), .q(idle_q)
    );

    // The bank only tracks read_index while idle, so it is frozen for the
    // whole window and a mid-window swap shows up from the next frame.
    dff_arn #(.W(1)) u_bank (
        .clk(clk), .reset_n(reset_n), .d(idle_q ? read_index : bank_q), .q(bank_q)
    );

    assign wave_display_idle = idle_q;
    assign read_address      = {bank_q, rel_x[IDX_W:1]};

    // S0 -> S1: carry pixel attributes alongside the RAM read.
    dff_arn #(.W(11)) u_s1 (
        .clk(clk), .reset_n(reset_n), .d({in_win, newcol, first, rel_y[7:0]}), .q(s1_q)
    );

    assign s1_in_win = s1_q[10];
    assign s1_newcol = s1_q[9];
    assign s1_first  = s1_q[8];
    assign s1_rel_y  = s1_q[7:0];

    // Sample history: only even in-window columns load a new sample, so odd
    // columns and bubbles leave the segment ends untouched. The first column
    // starts a fresh segment instead of joining the previous line's tail.
    always_comb begin
        cur_d  = cur_q;
        prev_d = prev_q;
        if (s1_newcol) begin
            cur_d  = read_value;
            prev_d = s1_first ? read_value : cur_q;
        end
    end

    dff_arn #(.W(SAMPLE_W)) u_cur (
        .clk(clk), .reset_n(reset_n), .d(cur_d), .q(cur_q)
    );

    dff_arn #(.W(SAMPLE_W)) u_prev (
        .clk(clk), .reset_n(reset_n), .d(prev_d), .q(prev_q)
    );

    // After a reset the history is meaningless until a line start reloads it.
    dff_arn #(.W(1)) u_seen (
        .clk(clk), .reset_n(reset_n), .d(seen_q | s1_first), .q(seen_q)
    );

    // S1 -> S2
    dff_arn #(.W(9)) u_s2 (
        .clk(clk), .reset_n(reset_n), .d({s1_in_win, s1_rel_y}), .q(s2_q)
    );

    assign s2_in_win = s2_q[8];
    assign s2_rel_y  = s2_q[7:0];

    // S2: the top window row maps to the largest sample value; a pixel is
    // lit when its row lies within the segment between the two samples.
    always_comb begin
        row = ~s2_rel_y;
        lo  = prev_q;
        hi  = cur_q;
        if (prev_q > cur_q) begin
            lo = cur_q;
            hi = prev_q;
        end
        hit   = s2_in_win & seen_q & (row >= lo) & (row <= hi);
        rgb_d = hit ? WAVE_COLOR : 24'h000000;
    end

    dff_arn #(.W(1)) u_vp (
        .clk(clk), .reset_n(reset_n), .d(s2_in_win), .q(valid_pixel)
    );

    dff_arn #(.W(24)) u_rgb (
        .clk(clk), .reset_n(reset_n), .d(rgb_d), .q(rgb_q)
    );

    assign pix = pixel_rgb_t'(rgb_q);
    assign r   = pix.r;
    assign g   = pix.g;
    assign b   = pix.b;

endmodule
